// File: rtl/alu_issue_stage.sv
// alu_issue_stage: EX issue register with 2-entry skid buffer, operand bypass and flush.
// Define ALU_ISSUE_FWD_EN to enable EX/MEM and MEM/WB bypass plus the load-use stall.
`ifndef ALU_OP_LEN
`define ALU_OP_LEN 4
`endif
`ifndef ALU_OP_NONE
`define ALU_OP_NONE 0
`endif

module alu_issue_stage #(
    parameter int OP_W   = `ALU_OP_LEN,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_rs_idx,
    input  logic [31:0]       in_rs_val,
    input  logic [REG_AW-1:0] in_rt_idx,
    input  logic [31:0]       in_rt_val,
    input  logic              in_use_imm,
    input  logic [31:0]       in_imm,
    input  logic [4:0]        in_shamt,
    input  logic [REG_AW-1:0] in_rd_idx,
    input  logic              fwd_ex_en,
    input  logic [REG_AW-1:0] fwd_ex_idx,
    input  logic [31:0]       fwd_ex_data,
    input  logic              fwd_ex_pend,
    input  logic              fwd_wb_en,
    input  logic [REG_AW-1:0] fwd_wb_idx,
    input  logic [31:0]       fwd_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic [31:0]       alu_in1,
    output logic [31:0]       alu_in2,
    output logic [4:0]        alu_shift_imm,
    output logic [REG_AW-1:0] out_rd_idx
);
    localparam logic [OP_W-1:0] OP_NONE = OP_W'(`ALU_OP_NONE);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [31:0]       in1;
        logic [31:0]       in2;
        logic [4:0]        sh;
        logic [REG_AW-1:0] rd;
    } entry_t;

    state_t      state, state_nx;
    entry_t      main_q, skid_q, cap;
    logic [31:0] rs_res, rt_res;
    logic        hazard, accept, load_main, load_skid;

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM wins over MEM/WB; index 0 never bypasses
    assign rs_res = (in_rs_idx == '0) ? '0 :
                    (fwd_ex_en && fwd_ex_idx == in_rs_idx) ? fwd_ex_data :
                    (fwd_wb_en && fwd_wb_idx == in_rs_idx) ? fwd_wb_data : in_rs_val;
    assign rt_res = (in_rt_idx == '0) ? '0 :
                    (fwd_ex_en && fwd_ex_idx == in_rt_idx) ? fwd_ex_data :
                    (fwd_wb_en && fwd_wb_idx == in_rt_idx) ? fwd_wb_data : in_rt_val;
    assign hazard = fwd_ex_pend && fwd_ex_idx != '0 &&
                    (fwd_ex_idx == in_rs_idx || (!in_use_imm && fwd_ex_idx == in_rt_idx));
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_ex_en, fwd_ex_idx, fwd_ex_data, fwd_ex_pend,
                          fwd_wb_en, fwd_wb_idx, fwd_wb_data};
    assign rs_res = in_rs_val;
    assign rt_res = in_rt_val;
    assign hazard = 1'b0;
`endif

    always_comb begin
        accept    = in_valid && in_ready && !hazard;
        cap       = {in_op, rs_res, in_use_imm ? in_imm : rt_res, in_shamt, in_rd_idx};
        state_nx  = flush ? EMPTY :
                    state == EMPTY ? (accept ? ONE : EMPTY) :
                    state == ONE   ? (accept ? (out_ready ? ONE : TWO) : (out_ready ? EMPTY : ONE)) :
                                     (out_ready ? ONE : TWO);
        // flush leaves data outputs untouched; only the occupancy is cleared
        load_main = !flush && ((state == EMPTY && accept) ||
                               (state == ONE && accept && out_ready) ||
                               (state == TWO && out_ready));
        load_skid = !flush && state == ONE && accept && !out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= {OP_NONE, 32'd0, 32'd0, 5'd0, {REG_AW{1'b0}}};
            skid_q   <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= state_nx != TWO;
            if (load_main) main_q <= (state == TWO) ? skid_q : cap;
            if (load_skid) skid_q <= cap;
        end
    end

    assign out_valid     = state != EMPTY;
    assign alu_op        = main_q.op;
    assign alu_in1       = main_q.in1;
    assign alu_in2       = main_q.in2;
    assign alu_shift_imm = main_q.sh;
    assign out_rd_idx    = main_q.rd;

endmodule
